spi_reg_bridge: RTL and testbench

Command decoder and register bank downstream of the mode-0 SPI slave. It consumes the slave's received-byte strobe and byte, and interprets the first byte of each chip-select frame as a command (R/W flag plus 7-bit address). Following bytes are written into, or read out of, an internal bank of 8-bit control registers with optional address auto-increment. It drives the slave's transmit byte so that read data appears on MISO in the byte immediately after the command, with no dummy byte.

---
 rtl/spi_reg_pkg.sv | 17 +
 rtl/spi_reg_bridge_sync_2ff.sv | 22 ++
 rtl/spi_reg_bridge.sv | 120 ++++++++++++
 tb/tb_spi_reg_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command decoder / register bank.
package spi_reg_pkg;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned CMD_WR_BIT = 7;

  localparam logic [7:0] IDLE_TX_BYTE  = 8'h00;
  localparam logic [7:0] OOR_READ_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_reg_bridge_sync_2ff.sv
// Two-stage 1-bit synchronizer; resets high so a raw chip select reads as
// deselected while reset is active.
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI command decoder and 8-bit register bank behind a mode-0 SPI slave.
// Define SPI_REG_BRIDGE_AUTOINC_EN to advance the address after each data byte.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned NREGS     = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               spi_cs_n,
  input  logic               rx_dv,
  input  logic [7:0]         rx_byte,
  output logic [7:0]         tx_byte,
  output logic [NREGS*8-1:0] regs_flat,
  output logic               wr_strobe,
  output logic [6:0]         wr_addr
);

  logic               cs_sync;
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_step;
  logic [7:0]         tx_q;
  logic [NREGS*8-1:0] regs_q;
  logic               latch_cmd;
  logic               wr_en;
  logic               rd_adv;
  logic               addr_in_range;

  sync_2ff u_cs_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (spi_cs_n),
    .q      (cs_sync)
  );

  // Loop-based mux keeps out-of-range addresses off the array index entirely.
  function automatic logic [7:0] reg_read(input logic [NREGS*8-1:0] bank,
                                          input logic [ADDR_W-1:0]  a);
    logic [7:0] val;
    val = OOR_READ_BYTE;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (a == ADDR_W'(i)) val = bank[8*i +: 8];
    end
    return val;
  endfunction

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  assign addr_step = addr_q + ADDR_W'(1);
`else
  assign addr_step = addr_q;
`endif

  assign addr_in_range = (32'(addr_q) < NREGS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A synchronized deselect overrides everything, including a coincident rx_dv.
  always_comb begin
    state_d   = state_q;
    latch_cmd = 1'b0;
    wr_en     = 1'b0;
    rd_adv    = 1'b0;
    if (cs_sync) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = CMD;
        CMD: begin
          if (rx_dv) begin
            latch_cmd = 1'b1;
            state_d   = rx_byte[CMD_WR_BIT] ? WRITE : READ;
          end
        end
        WRITE: wr_en  = rx_dv;
        READ:  rd_adv = rx_dv;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      tx_q      <= IDLE_TX_BYTE;
      regs_q    <= {NREGS{RESET_VAL}};
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (latch_cmd) begin
        addr_q <= rx_byte[ADDR_W-1:0];
        tx_q   <= reg_read(regs_q, rx_byte[ADDR_W-1:0]);
      end
      if (wr_en) begin
        addr_q <= addr_step;
        if (addr_in_range) begin
          wr_strobe <= 1'b1;
          wr_addr   <= addr_q;
        end
        for (int unsigned i = 0; i < NREGS; i++) begin
          if (addr_q == ADDR_W'(i)) regs_q[8*i +: 8] <= rx_byte;
        end
      end
      if (rd_adv) begin
        addr_q <= addr_step;
        tx_q   <= reg_read(regs_q, addr_step);
      end
    end
  end

  // Read data is only presented while a read frame is active.
  assign tx_byte   = (state_q == READ) ? tx_q : IDLE_TX_BYTE;
  assign regs_flat = regs_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: two instances (16 and 128 registers) share stimulus.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam logic AI = 1'b1;
`else
  localparam logic AI = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         rx_dv = 1'b0;
  logic [7:0]   rx_byte = 8'h00;

  logic [7:0]    tx16, tx128;
  logic [127:0]  regs_flat16;
  logic [1023:0] regs_flat128;
  logic          wr_strobe16, wr_strobe128;
  logic [6:0]    wr_addr16, wr_addr128;

  spi_reg_bridge #(.NREGS(16), .RESET_VAL(8'h00)) dut16 (
    .clk       (clk),
    .resetn    (resetn),
    .spi_cs_n  (spi_cs_n),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .tx_byte   (tx16),
    .regs_flat (regs_flat16),
    .wr_strobe (wr_strobe16),
    .wr_addr   (wr_addr16)
  );

  spi_reg_bridge #(.NREGS(128), .RESET_VAL(8'h5A)) dut128 (
    .clk       (clk),
    .resetn    (resetn),
    .spi_cs_n  (spi_cs_n),
    .rx_dv     (rx_dv),
    .rx_byte   (rx_byte),
    .tx_byte   (tx128),
    .regs_flat (regs_flat128),
    .wr_strobe (wr_strobe128),
    .wr_addr   (wr_addr128)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Strobe pulse counters
  int n16 = 0;
  int n128 = 0;
  always @(negedge clk) begin
    if (wr_strobe16 === 1'b1)  n16++;
    if (wr_strobe128 === 1'b1) n128++;
  end

  logic       s16, s128;
  logic [6:0] a16, a128;
  logic [7:0] miso16, miso128;

  function automatic logic [7:0] r16(input int i);
    return regs_flat16[8*i +: 8];
  endfunction

  function automatic logic [7:0] r128(input int i);
    return regs_flat128[8*i +: 8];
  endfunction

  task automatic cs_fall();
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_rise();
    @(negedge clk) spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One received byte; captures strobe 1 clk later and the next MISO byte 3 clk later.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    s16  = wr_strobe16;
    a16  = wr_addr16;
    s128 = wr_strobe128;
    a128 = wr_addr128;
    repeat (3) @(negedge clk);
    miso16  = tx16;
    miso128 = tx128;
    repeat (4) @(negedge clk);
  endtask

  logic [127:0] exp16;
  int           ecnt16;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_regs16", regs_flat16, 128'h0);
    check("rst_regs128", regs_flat128 == {128{8'h5A}}, 1);
    check("rst_tx16", tx16, 8'h00);
    check("rst_strobe", wr_strobe16, 0);
    check("rst_waddr", wr_addr16, 0);
    check("rst_state", dut16.state_q, IDLE);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(negedge clk);
    exp16  = '0;
    ecnt16 = 0;

    // Write burst 0x83, 0x11, 0x22
    cs_fall();
    check("cmd_tx16", tx16, 8'h00);
    send(8'h83);
    send(8'h11);
    check("wb_s1", s16, 1);
    check("wb_a1", a16, 3);
    send(8'h22);
    check("wb_s2", s16, 1);
    check("wb_a2", a16, AI ? 7'd4 : 7'd3);
    cs_rise();
    exp16[24 +: 8] = AI ? 8'h11 : 8'h22;
    exp16[32 +: 8] = AI ? 8'h22 : 8'h00;
    ecnt16 = 2;
    check("wb_regs16", regs_flat16, exp16);
    check("wb_cnt16", n16, ecnt16);
    check("wb_reg3_128", r128(3), AI ? 8'h11 : 8'h22);

    // Preload reg5 / reg6 with separate frames
    cs_fall(); send(8'h85); send(8'hAB); cs_rise();
    cs_fall(); send(8'h86); send(8'hCD); cs_rise();
    exp16[40 +: 8] = 8'hAB;
    exp16[48 +: 8] = 8'hCD;
    ecnt16 = 4;

    // Read burst 0x05, 0x00, 0x00
    cs_fall();
    check("rd_m0", tx16, 8'h00);
    send(8'h05);
    check("rd_m1", miso16, 8'hAB);
    send(8'h00);
    check("rd_m2", miso16, AI ? 8'hCD : 8'hAB);
    send(8'h00);
    cs_rise();
    check("rd_idle_tx", tx16, 8'h00);
    check("rd_cnt16", n16, ecnt16);

    // Out-of-range write/read (address 16)
    cs_fall();
    send(8'h90);
    send(8'h77);
    check("oor_s16", s16, 0);
    check("oor_s128", s128, 1);
    check("oor_a128", a128, 16);
    cs_rise();
    check("oor_regs16", regs_flat16, exp16);
    check("oor_cnt16", n16, ecnt16);
    check("oor_reg128", r128(16), 8'h77);
    cs_fall();
    send(8'h10);
    check("oor_rd16", miso16, 8'h00);
    check("oor_rd128", miso128, 8'h77);
    cs_rise();

    // Address wrap 127 -> 0
    cs_fall();
    send(8'hFF);
    send(8'h01);
    check("wrap_s16a", s16, 0);
    check("wrap_a128a", a128, 127);
    send(8'h02);
    check("wrap_s16b", s16, AI);
    cs_rise();
    check("wrap_r127", r128(127), AI ? 8'h01 : 8'h02);
    check("wrap_r0", r128(0), AI ? 8'h02 : 8'h5A);
    exp16[0 +: 8] = AI ? 8'h02 : 8'h00;
    ecnt16 = AI ? 5 : 4;
    check("wrap_regs16", regs_flat16, exp16);
    check("wrap_cnt16", n16, ecnt16);

    // Abort mid data byte: cs_n rises with no rx_dv
    cs_fall();
    send(8'h87);
    repeat (32) @(negedge clk);
    @(negedge clk) spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ab_state", dut16.state_q, IDLE);
    check("ab_regs16", regs_flat16, exp16);
    check("ab_cnt16", n16, ecnt16);
    repeat (2) @(negedge clk);
    cs_fall();
    send(8'h87);
    send(8'h3C);
    cs_rise();
    exp16[56 +: 8] = 8'h3C;
    ecnt16++;
    check("ab_next_r7", r16(7), 8'h3C);
    check("ab_next_cnt", n16, ecnt16);

    // rx_dv coincident with synchronized cs_n rise is discarded
    cs_fall();
    send(8'h88);
    @(negedge clk) spi_cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = 8'h99;
    @(negedge clk) rx_dv = 1'b0;
    repeat (3) @(negedge clk);
    check("coinc_regs16", regs_flat16, exp16);
    check("coinc_cnt16", n16, ecnt16);

    // Reset mid read frame
    cs_fall();
    send(8'h05);
    check("pre_rst_tx", tx16, 8'hAB);
    @(negedge clk) resetn = 1'b0;
    @(negedge clk);
    check("mrst_regs16", regs_flat16, 128'h0);
    check("mrst_regs128", regs_flat128 == {128{8'h5A}}, 1);
    check("mrst_tx16", tx16, 8'h00);
    check("mrst_state", dut16.state_q, IDLE);
    check("mrst_waddr", wr_addr16, 0);
    @(negedge clk) resetn = 1'b1;
    cs_rise();
    exp16 = '0;

    // 0x82, 0x01, 0x02
    cs_fall();
    send(8'h82);
    send(8'h01);
    send(8'h02);
    cs_rise();
    exp16[16 +: 8] = AI ? 8'h01 : 8'h02;
    exp16[24 +: 8] = AI ? 8'h02 : 8'h00;
    check("fix_r2", r16(2), AI ? 8'h01 : 8'h02);
    check("fix_r3", r16(3), AI ? 8'h02 : 8'h00);
    check("fix_regs16", regs_flat16, exp16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
